keypad_scanner: RTL and testbench

Scans a 4x4 active-low key matrix and reports debounced key presses as 4-bit hex codes with a one-cycle strobe. It is the input-side counterpart of the 8-digit hex display driver. It shares that driver's time-multiplexed scanning style, but drives rows and senses columns instead of driving cathodes and segments. The optional entry register produces a 32-bit word that connects directly to the display's `data` input.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 124 ++++++++++++
 rtl/keypad_scanner.sv | 109 ++++++++++
 tb/tb_keypad_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// "No key" is carried as a separate valid flag, never as an in-band code.
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;
  localparam int KP_KEYS   = KP_ROWS * KP_COLS;

  typedef enum logic [1:0] {
    KP_IDLE,
    KP_PRESS,
    KP_HELD,
    KP_RELEASE
  } kp_state_e;

  typedef struct packed {
    logic                 valid;
    logic [KP_CODE_W-1:0] code;
  } kp_cand_t;

  // Lowest set index wins when several keys are down together.
  function automatic kp_cand_t kp_lowest_key(input logic [KP_KEYS-1:0] frame);
    kp_cand_t c;
    c = '0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (frame[i]) begin
        c.valid = 1'b1;
        c.code  = KP_CODE_W'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: turns one candidate per scanned frame into
// accepted key presses (strobe + code) and a debounced held flag.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_done_i,
  input  logic                 cand_valid_i,
  input  logic [KP_CODE_W-1:0] cand_code_i,
  output logic [KP_CODE_W-1:0] key_code_o,
  output logic                 key_valid_o,
  output logic                 key_held_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  kp_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KP_CODE_W-1:0] latch_q, latch_d;
  logic [KP_CODE_W-1:0] code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 held_q, held_d;

  logic             hit;
  logic [CNT_W-1:0] cnt_inc;

  assign hit     = cand_valid_i && (cand_code_i == latch_q);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= KP_IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    code_d  = code_q;
    valid_d = 1'b0;

    if (frame_done_i) begin
      unique case (state_q)
        KP_IDLE: begin
          if (cand_valid_i) begin
            latch_d = cand_code_i;
            cnt_d   = CNT_ONE;
            // A single-frame debounce accepts on the frame that saw the key.
            if (DEBOUNCE_CNT == 1) begin
              state_d = KP_HELD;
              code_d  = cand_code_i;
              valid_d = 1'b1;
            end else begin
              state_d = KP_PRESS;
            end
          end
        end
        KP_PRESS: begin
          if (!cand_valid_i) begin
            state_d = KP_IDLE;
            cnt_d   = '0;
          end else if (hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = KP_HELD;
              code_d  = latch_q;
              valid_d = 1'b1;
            end
          end else begin
            latch_d = cand_code_i;
            cnt_d   = CNT_ONE;
          end
        end
        KP_HELD: begin
          if (!hit) begin
            state_d = KP_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        KP_RELEASE: begin
          // The same key coming back resumes the hold without a new strobe.
          if (hit) begin
            state_d = KP_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = KP_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = KP_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = (state_d == KP_HELD) || (state_d == KP_RELEASE);
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_held_o  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row sequencing, column sync, frame snapshot.
// Optional hex entry shift register enabled by defining KEYPAD_SHIFT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [KP_ROWS-1:0]   row,
  input  logic [KP_COLS-1:0]   col,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  output logic                 key_held,
  output logic [31:0]          entry
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(KP_ROWS);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(KP_ROWS - 1);

  logic [KP_COLS-1:0] col_meta_q, col_sync_q;
  logic [DIV_W-1:0]   dwell_q, dwell_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [KP_COLS-1:0] snap_q [KP_ROWS];
  logic [KP_KEYS-1:0] frame_flat;
  logic               dwell_last;
  logic               frame_done;
  kp_cand_t           cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      dwell_q    <= '0;
      row_idx_q  <= '0;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
      dwell_q    <= dwell_d;
      row_idx_q  <= row_idx_d;
    end
  end

  assign dwell_last = (dwell_q == DWELL_LAST);

  always_comb begin
    dwell_d   = dwell_q + DIV_W'(1);
    row_idx_d = row_idx_q;
    if (dwell_last) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + ROW_W'(1);
    end
  end

  assign row = ~(4'b0001 << row_idx_q);

  // The row being sampled this cycle bypasses its snapshot slot so the
  // complete frame is visible on the same cycle as frame_done.
  for (genvar gi = 0; gi < KP_ROWS; gi++) begin : g_row
    logic row_sample;
    assign row_sample = dwell_last && (row_idx_q == ROW_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        snap_q[gi] <= '0;
      end else if (row_sample) begin
        snap_q[gi] <= ~col_sync_q;
      end
    end

    assign frame_flat[gi*KP_COLS +: KP_COLS] = row_sample ? ~col_sync_q : snap_q[gi];
  end

  assign frame_done = dwell_last && (row_idx_q == ROW_LAST);
  assign cand       = kp_lowest_key(frame_flat);

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_done_i(frame_done),
    .cand_valid_i(cand.valid),
    .cand_code_i (cand.code),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_held_o  (key_held)
  );

`ifdef KEYPAD_SHIFT_EN
  logic [31:0] entry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else if (key_valid) begin
      entry_q <= {entry_q[27:0], key_code};
    end
  end

  assign entry = entry_q;
`else
  assign entry = 32'h0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_CNT=3) with a frame-level reference model.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DC = 3;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] entry;

  logic [15:0] keys_down = '0;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // reference model state, advanced once per completed frame
  int          cyc = 0;
  bit          m_held = 0;
  int          m_pend = -1;
  int          m_streak = 0;
  int          m_gone = 0;
  logic [3:0]  exp_code = '0;
  logic        exp_valid = 1'b0;
  logic        exp_held = 1'b0;
  logic [31:0] exp_entry = '0;

  always #5 clk = ~clk;

  // physical key matrix: a pressed key shorts its driven row to its column
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys_down[r*4+c]) col[c] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .entry    (entry)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_frame(input logic [15:0] k);
    int cand;
    cand = -1;
    for (int i = 0; i < 16; i++)
      if (k[i] && cand < 0) cand = i;
    if (!m_held) begin
      if (cand >= 0 && cand == m_pend && m_streak > 0) m_streak++;
      else if (cand >= 0) begin
        m_pend = cand;
        m_streak = 1;
      end else m_streak = 0;
      if (m_streak >= DC) begin
        m_held = 1;
        m_gone = 0;
        exp_code = 4'(m_pend);
        exp_valid = 1'b1;
      end
    end else begin
      if (cand == int'(exp_code)) m_gone = 0;
      else m_gone++;
      if (m_gone >= DC) begin
        m_held = 0;
        m_streak = 0;
      end
    end
    exp_held = m_held;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0;
      m_held = 0;
      m_pend = -1;
      m_streak = 0;
      m_gone = 0;
      exp_code = '0;
      exp_valid = 1'b0;
      exp_held = 1'b0;
      exp_entry = '0;
    end else begin
      cyc++;
`ifdef KEYPAD_SHIFT_EN
      if (exp_valid) exp_entry = {exp_entry[27:0], exp_code};
`endif
      exp_valid = 1'b0;
      if (cyc % FRAME == 0) model_frame(keys_down);
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_row = ~(4'b0001 << ((cyc / SD) % 4));
    check("row", 32'(row), 32'(exp_row));
    check("key_valid", 32'(key_valid), 32'(exp_valid));
    check("key_code", 32'(key_code), 32'(exp_code));
    check("key_held", 32'(key_held), 32'(exp_held));
    check("entry", entry, exp_entry);
    if (key_valid) begin
      pulses++;
      $display("press: code=%h held=%0d entry=%h", key_code, key_held, entry);
    end
  end

  // starts and ends at negedge+1 of a frame's first cycle
  task automatic set_keys(input logic [15:0] k, input int n);
    keys_down = k;
    repeat (FRAME * n) @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [3:0] row_tbl [4];
    logic [15:0] k;
    int p0;
    row_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // reset, then release and assert again in the middle of a frame
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (13) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_row", 32'(row), 32'(4'b1110));
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_entry", entry, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    // row sequence, 8 cycles per step
    check("scan_row0", 32'(row), 32'(row_tbl[0]));
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      check("scan_row", 32'(row), 32'(row_tbl[i / SD]));
    end
    @(negedge clk);
    #1;

    // single key row 2 col 1 -> code 9
    p0 = pulses;
    set_keys(16'h0200, 2);
    check("single_early", 32'(pulses - p0), 32'd0);
    set_keys(16'h0200, 1);
    check("single_pulse", 32'(pulses - p0), 32'd1);
    check("single_code", 32'(key_code), 32'h9);
    check("single_held", 32'(key_held), 32'd1);
    set_keys(16'h0200, 2);
    check("single_once", 32'(pulses - p0), 32'd1);
    set_keys(16'h0000, 2);
    check("release_still", 32'(key_held), 32'd1);
    set_keys(16'h0000, 1);
    check("release_drop", 32'(key_held), 32'd0);

    // bounce: toggle every frame, then hold
    p0 = pulses;
    set_keys(16'h0200, 1);
    set_keys(16'h0000, 1);
    set_keys(16'h0200, 1);
    set_keys(16'h0000, 1);
    check("bounce_none", 32'(pulses - p0), 32'd0);
    set_keys(16'h0200, 3);
    check("bounce_accept", 32'(pulses - p0), 32'd1);
    set_keys(16'h0000, 3);

    // two keys: lowest index wins; the other needs full release then press
    set_keys(16'h0048, 3);
    check("two_code", 32'(key_code), 32'h3);
    set_keys(16'h0040, 5);
    check("two_wait", 32'(key_code), 32'h3);
    check("two_idle", 32'(key_held), 32'd0);
    set_keys(16'h0040, 1);
    check("two_switch", 32'(key_code), 32'h6);
    set_keys(16'h0000, 3);

    // brief one-frame release
    p0 = pulses;
    set_keys(16'h0020, 3);
    set_keys(16'h0000, 1);
    check("brief_held", 32'(key_held), 32'd1);
    set_keys(16'h0020, 3);
    check("brief_held2", 32'(key_held), 32'd1);
    check("brief_once", 32'(pulses - p0), 32'd1);

    // reset mid-frame while a key is held
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    keys_down = '0;
    #1;
    check("rst2_row", 32'(row), 32'(4'b1110));
    check("rst2_held", 32'(key_held), 32'd0);
    check("rst2_code", 32'(key_code), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // entry register: keys 1..9
    for (int d = 1; d <= 9; d++) begin
      k = 16'h0001 << d;
      set_keys(k, 3);
      set_keys(16'h0000, 3);
    end
`ifdef KEYPAD_SHIFT_EN
    check("entry_word", entry, 32'h23456789);
`else
    check("entry_word", entry, 32'h0);
`endif

    // randomized key traffic against the model
    k = '0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: k = '0;
        1: k = 16'h0001 << $urandom_range(0, 15);
        2: k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: k = k;
      endcase
      set_keys(k, int'($urandom_range(1, 4)));
    end
    set_keys(16'h0000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
